// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async 8-bit SRAM between two requesters.
// Each grant runs SETUP -> ACCESS (WAIT_CYCLES) -> HOLD with registered pin controls.
module sram_arbiter #(
  parameter int AW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [7:0]    wdata0,
  output logic          ack0,
  output logic [7:0]    rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    wdata1,
  output logic          ack1,
  output logic [7:0]    rdata1,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  input  logic [7:0]    sram_din,
  output logic          sram_oe,
  output logic          sram_we_n,
  output logic          busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_last_grant;
  logic          r_port;
  logic          r_we;
  logic          r_ack0;
  logic          r_ack1;
  logic [7:0]    r_rdata0;
  logic [7:0]    r_rdata1;
  logic [AW-1:0] r_sram_addr;
  logic [7:0]    r_sram_dout;
  logic          r_sram_oe;
  logic          r_sram_we_n;
  logic          r_busy;

  logic          w_grant_valid;
  logic          w_grant_port;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_wdata;

  assign w_grant_valid = req0 | req1;
  assign w_we          = w_grant_port ? we1 : we0;
  assign w_addr        = w_grant_port ? addr1 : addr0;
  assign w_wdata       = w_grant_port ? wdata1 : wdata0;

  // Round-robin pick: on contention the port that did not win last time is served.
  always_comb begin
    w_grant_port = 1'b0;
    if (req0 && req1) begin
      w_grant_port = ~r_last_grant;
    end else if (req1) begin
      w_grant_port = 1'b1;
    end else begin
      w_grant_port = 1'b0;
    end
  end

  // Transaction sequencer; all SRAM pin controls and acks are driven from registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= 8'h00;
      r_rdata1     <= 8'h00;
      r_sram_addr  <= '0;
      r_sram_dout  <= 8'h00;
      r_sram_oe    <= 1'b0;
      r_sram_we_n  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_state      <= S_SETUP;
            r_last_grant <= w_grant_port;
            r_port       <= w_grant_port;
            r_we         <= w_we;
            r_sram_addr  <= w_addr;
            r_sram_dout  <= w_wdata;
            r_sram_oe    <= w_we;
            r_sram_we_n  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state     <= S_ACCESS;
          r_cnt       <= LP_WAIT_LAST;
          r_sram_we_n <= ~r_we;
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            // WEn rises here while address and data stay put through HOLD.
            r_state     <= S_HOLD;
            r_sram_we_n <= 1'b1;
            if (!r_we) begin
              if (r_port) begin
                r_rdata1 <= sram_din;
              end else begin
                r_rdata0 <= sram_din;
              end
            end
            if (r_port) begin
              r_ack1 <= 1'b1;
            end else begin
              r_ack0 <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_state   <= S_IDLE;
          r_sram_oe <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sram_oe   <= 1'b0;
          r_sram_we_n <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign sram_addr = r_sram_addr;
  assign sram_dout = r_sram_dout;
  assign sram_oe   = r_sram_oe;
  assign sram_we_n = r_sram_we_n;
  assign busy      = r_busy;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single external async 8-bit SRAM between two requesters: port 0 (6502 core bus) and port 1 (UART loader/DMA). It arbitrates round-robin, latches the winning request, and sequences one SRAM transaction per grant: address/data setup, WEn strobe or read sampling, then hold. It sits between the logic block and the top-level SB_IO data-bus tristate/address pins, and owns sram_oe (data-bus output enable) and WEn.

Parameters:
AW, 16, address width of requester ports and sram_addr
WAIT_CYCLES, 2, number of ACCESS-state cycles (strobe/read window); legal range 1..15

Ports:
clk  input  1  system clock (divided core clock)
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 request; held with we0/addr0/wdata0 stable until ack0
we0  input  1  port 0: 1 = write, 0 = read
addr0  input  AW  port 0 address
wdata0  input  8  port 0 write data
ack0  output  1  port 0 one-cycle completion pulse
rdata0  output  8  port 0 read data, valid with ack0, held until next port 0 read completes
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
sram_addr  output  AW  SRAM address pins
sram_dout  output  8  data driven onto SRAM bus when sram_oe=1
sram_din  input  8  data sampled from SRAM bus
sram_oe  output  1  1 = FPGA drives data bus (writes only)
sram_we_n  output  1  SRAM write strobe, active low
busy  output  1  1 whenever state != IDLE

Behaviour:
- All outputs registered. Reset values: state IDLE, ack0=ack1=0, rdata0=rdata1=0, sram_addr=0, sram_dout=0, sram_oe=0, sram_we_n=1, busy=0, last_grant=1 (so port 0 wins the first contested grant).
- States: IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles, internal 4-bit counter) -> HOLD (1 cycle) -> IDLE.
- IDLE: at each edge, if exactly one req is high, grant it; if both are high, grant the port != last_grant; update last_grant to the granted port. On grant: latch we, addr to sram_addr, wdata to sram_dout, record granted port; go SETUP.
- SETUP: address stable. Write: sram_oe=1, sram_we_n=1. Read: sram_oe=0.
- ACCESS: write: sram_oe=1, sram_we_n=0 for all WAIT_CYCLES cycles. Read: sram_oe=0; on the edge leaving ACCESS, sram_din is captured into rdata of the granted port.
- HOLD: sram_we_n=1; write keeps sram_oe=1 and sram_dout/sram_addr unchanged (data hold after WEn rising); ack of granted port =1 for this cycle only. Next edge: IDLE, sram_oe=0.
- Latency: grant edge to ack cycle = WAIT_CYCLES+2 cycles; a transaction occupies WAIT_CYCLES+3 cycles including the return-to-IDLE cycle. Max throughput: one access per WAIT_CYCLES+3 cycles.
- Requesters must drop req on the edge where they observe ack; req still high in the IDLE cycle after HOLD is a new request.
- sram_addr and sram_dout hold their last values in IDLE; sram_oe and sram_we_n never change mid-transaction except as stated. sram_we_n=0 implies sram_oe=1 in every cycle.
- Changes of req/addr/we/wdata of the granted port after grant are ignored until ack. The non-granted port's req is unaffected and waits.
- Fairness: with both ports requesting continuously, grants strictly alternate; neither port waits more than one transaction.
- Asynchronous reset mid-transaction: immediately sram_we_n=1, sram_oe=0, no ack issued, FSM to IDLE, last_grant=1; the aborted write is undefined in SRAM.

Test Plan:
- Port 0 read, addr0=0x1234, SRAM model returns 0xA5, WAIT_CYCLES=2 -> sram_addr=0x1234 from SETUP, sram_oe=0 throughout, ack0 pulse 4 cycles after grant edge, rdata0=0xA5 and held after.
- Port 1 write addr1=0x00FF, wdata1=0x3C -> SETUP oe=1/we_n=1, exactly 2 cycles we_n=0, HOLD oe=1/we_n=1 with data 0x3C, ack1 one cycle; model memory[0x00FF]=0x3C.
- req0 and req1 rise on the same edge after reset -> port 0 served first, then port 1; ack0 then ack1, 5 cycles apart.
- Both ports request continuously (re-raise req one cycle after ack) for 6 transactions -> grant order 0,1,0,1,0,1; no back-to-back grants to the same port.
- Assert reset during ACCESS of a write -> same cycle sram_we_n=1, sram_oe=0, busy=0; no ack; next req0 read completes normally.
- WAIT_CYCLES=1 build, write then read of 0x5A at 0x0010 -> one we_n-low cycle, ack 3 cycles after grant, readback 0x5A.
